// File: rtl/rsc_dec_iter_ctrl.sv
// Half-iteration scheduler for the duobinary RSC turbo decoder: CLEAR/RUN/FLUSH per half, natural then permuted.
// Optional early stop on istop when RSC_DEC_ITER_CTRL_EARLY_STOP_EN is defined.
module rsc_dec_iter_ctrl #(
  parameter int pW       = 13,
  parameter int pNITER_W = 5,
  parameter int pFLUSH   = 4
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                istart,
  input  logic                iabort,
  input  logic [pW-1:0]       iN,
  input  logic [pNITER_W-1:0] iNiter,
  input  logic                istop,
  output logic                ordy,
  output logic                oclear,
  output logic                oenable,
  output logic                opmode,
  output logic [pNITER_W-1:0] oiter,
  output logic                ofirst,
  output logic                olast,
  output logic                odone
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic [pW-1:0] CLEAR_LAST = pW'(1);
  localparam logic [pW-1:0] FLUSH_LAST = pW'(pFLUSH - 1);

  state_t                state;
  logic [pW-1:0]         cnt;
  logic [pW-1:0]         nm1;
  logic [pNITER_W-1:0]   nim1;
  logic                  stop_req;
  logic                  last_half;

`ifdef RSC_DEC_ITER_CTRL_EARLY_STOP_EN
  assign stop_req = istop;
`else
  logic unused_istop;
  assign unused_istop = istop;
  assign stop_req     = 1'b0;
`endif

  assign last_half = opmode & (oiter == nim1);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      nm1     <= '0;
      nim1    <= '0;
      ordy    <= 1'b1;
      oclear  <= 1'b0;
      oenable <= 1'b0;
      opmode  <= 1'b0;
      oiter   <= '0;
      ofirst  <= 1'b0;
      olast   <= 1'b0;
      odone   <= 1'b0;
    end else if (iclkena) begin
      if (iabort) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        ordy    <= 1'b1;
        oclear  <= 1'b0;
        oenable <= 1'b0;
        opmode  <= 1'b0;
        oiter   <= '0;
        ofirst  <= 1'b0;
        olast   <= 1'b0;
        odone   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (istart) begin
              ordy <= 1'b0;
              cnt  <= '0;
              if (iN != '0) begin
                nm1    <= iN - pW'(1);
                nim1   <= (iNiter == '0) ? '0 : iNiter - pNITER_W'(1);
                state  <= ST_CLEAR;
                oclear <= 1'b1;
                opmode <= 1'b0;
                oiter  <= '0;
                ofirst <= 1'b1;
                olast  <= 1'b0;
              end else begin
                state <= ST_DONE;
                odone <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            if (cnt == CLEAR_LAST) begin
              state   <= ST_RUN;
              cnt     <= '0;
              oclear  <= 1'b0;
              oenable <= 1'b1;
            end else begin
              cnt <= cnt + pW'(1);
            end
          end
          ST_RUN: begin
            if (cnt == nm1) begin
              state   <= ST_FLUSH;
              cnt     <= '0;
              oenable <= 1'b0;
            end else begin
              cnt <= cnt + pW'(1);
            end
          end
          ST_FLUSH: begin
            if (cnt == FLUSH_LAST) begin
              cnt <= '0;
              // Block ends only after a permuted half; oiter then reports completed iterations.
              if (opmode && (last_half || stop_req)) begin
                state  <= ST_DONE;
                odone  <= 1'b1;
                opmode <= 1'b0;
                oiter  <= oiter + pNITER_W'(1);
                ofirst <= 1'b0;
                olast  <= 1'b0;
              end else begin
                state  <= ST_CLEAR;
                oclear <= 1'b1;
                opmode <= ~opmode;
                olast  <= ~opmode & (oiter == nim1);
                if (opmode) begin
                  oiter  <= oiter + pNITER_W'(1);
                  ofirst <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + pW'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            odone <= 1'b0;
            ordy  <= 1'b1;
            oiter <= '0;
          end
          default: begin
            state <= ST_IDLE;
            ordy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rsc_dec_iter_ctrl.sv
// Self-checking bench for rsc_dec_iter_ctrl: per-cycle comparison against a schedule built from the half-iteration rules.
// Honours RSC_DEC_ITER_CTRL_EARLY_STOP_EN when computing the expected number of halves.
module tb_rsc_dec_iter_ctrl;

  localparam int W  = 13;
  localparam int NW = 5;
  localparam int F  = 4;

  typedef struct packed {
    logic          rdy;
    logic          clr;
    logic          ena;
    logic          pm;
    logic [NW-1:0] it;
    logic          fst;
    logic          lst;
    logic          dn;
  } out_t;

  logic          iclk = 1'b0;
  logic          ireset = 1'b0;
  logic          iclkena = 1'b1;
  logic          istart = 1'b0;
  logic          iabort = 1'b0;
  logic [W-1:0]  iN = '0;
  logic [NW-1:0] iNiter = '0;
  logic          istop = 1'b0;
  logic          ordy, oclear, oenable, opmode, ofirst, olast, odone;
  logic [NW-1:0] oiter;
  out_t          act;

  int n_run  = 0;
  int n_fail = 0;
  out_t exp_q[$];

  rsc_dec_iter_ctrl #(.pW(W), .pNITER_W(NW), .pFLUSH(F)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart), .iabort(iabort),
    .iN(iN), .iNiter(iNiter), .istop(istop), .ordy(ordy), .oclear(oclear),
    .oenable(oenable), .opmode(opmode), .oiter(oiter), .ofirst(ofirst),
    .olast(olast), .odone(odone)
  );

  always #5 iclk = ~iclk;

  assign act = {ordy, oclear, oenable, opmode, oiter, ofirst, olast, odone};

  function automatic out_t idle_e();
    out_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Expected output sequence, entry 0 = cycle after the istart edge.
  task automatic build_model(input int n, input int niter, input int stop_iter, input int abort_k);
    int nit, halves;
    out_t e;
    exp_q.delete();
    nit = (niter == 0) ? 1 : niter;
    if (n == 0) begin
      e = '0;
      e.dn = 1'b1;
      exp_q.push_back(e);
    end else begin
      halves = 2 * nit;
`ifdef RSC_DEC_ITER_CTRL_EARLY_STOP_EN
      if (stop_iter >= 0 && stop_iter < nit - 1) halves = 2 * (stop_iter + 1);
`endif
      for (int h = 0; h < halves; h++) begin
        for (int c = 0; c < 2 + n + F; c++) begin
          e = '0;
          e.clr = (c < 2);
          e.ena = (c >= 2) && (c < 2 + n);
          e.pm  = 1'(h % 2);
          e.it  = NW'(h / 2);
          e.fst = (h / 2 == 0);
          e.lst = (h == 2 * nit - 1);
          exp_q.push_back(e);
        end
      end
      e = '0;
      e.dn = 1'b1;
      e.it = NW'(halves / 2);
      exp_q.push_back(e);
    end
    if (abort_k > 0)
      while (exp_q.size() > abort_k) void'(exp_q.pop_back());
    for (int i = 0; i < 3; i++) exp_q.push_back(idle_e());
  endtask

  task automatic run_block(input string name, input int n, input int niter, input bit rand_ena,
                           input int stop_iter, input int abort_k);
    int idx;
    out_t e;
    build_model(n, niter, stop_iter, abort_k);
    @(negedge iclk);
    iN = W'(n); iNiter = NW'(niter); istart = 1'b1; iclkena = 1'b1; iabort = 1'b0; istop = 1'b0;
    idx = 0;
    while (1) begin
      @(negedge iclk);
      n_run++;
      if (act !== exp_q[idx]) begin
        n_fail++;
        $display("FAIL %s idx %0d: got %h expected %h", name, idx, act, exp_q[idx]);
      end
      if (idx == exp_q.size() - 1) break;
      e       = exp_q[idx];
      istart  = e.dn ? 1'b1 : (!e.rdy && ($urandom % 4 == 0));
      iN      = W'($urandom);
      iNiter  = NW'($urandom);
      iabort  = (abort_k > 0) && (idx == abort_k - 1);
      istop   = !e.rdy && !e.dn && e.pm && (int'(e.it) == stop_iter);
      iclkena = rand_ena ? 1'($urandom) : 1'b1;
      if (iclkena) idx++;
    end
    istart = 1'b0; iabort = 1'b0; istop = 1'b0; iclkena = 1'b1;
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    repeat (3) @(negedge iclk);
    n_run++;
    if (act !== idle_e()) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", act, idle_e());
    end
    ireset = 1'b1;
    @(negedge iclk);
    n_run++;
    if (act !== idle_e()) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", act, idle_e());
    end
  endtask

  task automatic test_reset_mid();
    @(negedge iclk);
    iN = W'(8); iNiter = NW'(2); istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    repeat (12) @(negedge iclk);
    ireset = 1'b0;
    #1;
    n_run++;
    if (act !== idle_e()) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", act, idle_e());
    end
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);
    n_run++;
    if (act !== idle_e()) begin
      n_fail++;
      $display("FAIL reset_after: got %h expected %h", act, idle_e());
    end
  endtask

  task automatic test_basic();
    run_block("t1_n8_it1", 8, 1, 1'b0, -1, 0);
    run_block("t2_n4_it3", 4, 3, 1'b0, -1, 0);
  endtask

  task automatic test_degenerate();
    run_block("t3_n0", 0, 5, 1'b0, -1, 0);
    run_block("t3_niter0", 3, 0, 1'b0, -1, 0);
    run_block("n1_it1", 1, 1, 1'b0, -1, 0);
  endtask

  task automatic test_abort();
    run_block("t4_abort", 16, 2, 1'b0, -1, 2 * (2 + 16 + F) + 2 + 7);
    run_block("t4_after", 16, 2, 1'b0, -1, 0);
  endtask

  task automatic test_clkena();
    run_block("t5_clkena", 8, 2, 1'b1, -1, 0);
  endtask

  task automatic test_early_stop();
    run_block("t6_stop", 8, 4, 1'b0, 1, 0);
  endtask

  task automatic test_back_to_back();
    run_block("b2b_a", 2, 1, 1'b0, -1, 0);
    run_block("b2b_b", 3, 2, 1'b0, -1, 0);
  endtask

  task automatic test_random();
    int n, nit, st, ab;
    for (int k = 0; k < 8; k++) begin
      n   = $urandom_range(0, 6);
      nit = $urandom_range(0, 3);
      st  = $urandom_range(0, 3) - 1;
      ab  = ($urandom % 3 == 0 && n > 0) ? $urandom_range(1, 2 * ((nit == 0) ? 1 : nit) * (2 + n + F)) : 0;
      run_block("random", n, nit, 1'($urandom), st, ab);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_degenerate();
    test_abort();
    test_clkena();
    test_early_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
